// File: rtl/park_transform.sv
// Forward Park transform: (alpha, beta) -> (d, q) with supplied sin/cos.
// One shared signed multiplier stepped through four products by the FSM; results saturate.
module park_transform #(
    parameter int D_WIDTH = 32,
    parameter int Q_BITS  = 10
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic signed [D_WIDTH-1:0] alpha,
    input  logic signed [D_WIDTH-1:0] beta,
    input  logic signed [D_WIDTH-1:0] sin,
    input  logic signed [D_WIDTH-1:0] cos,
    input  logic                      start,
    output logic signed [D_WIDTH-1:0] d,
    output logic signed [D_WIDTH-1:0] q,
    output logic                      done,
    output logic                      busy
);
    localparam int PW = 2 * D_WIDTH;
    localparam int AW = PW + 1;
    localparam logic signed [AW-1:0] ACC_MAX = {{(D_WIDTH + 2){1'b0}}, {(D_WIDTH - 1){1'b1}}};
    localparam logic signed [AW-1:0] ACC_MIN = {{(D_WIDTH + 2){1'b1}}, {(D_WIDTH - 1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_P0, S_P1, S_P2, S_P3, S_OUT} state_t;

    state_t                    r_state;
    logic signed [D_WIDTH-1:0] r_alpha, r_beta, r_sin, r_cos;
    logic signed [AW-1:0]      r_acc_d, r_acc_q;

    logic signed [D_WIDTH-1:0] w_opa, w_opb;
    logic signed [PW-1:0]      w_ext_a, w_ext_b, w_prod, w_shift;
    logic signed [AW-1:0]      w_term;

    always_comb begin
        w_opa = '0;
        w_opb = '0;
        case (r_state)
            S_P0:    begin w_opa = r_alpha; w_opb = r_cos; end
            S_P1:    begin w_opa = r_beta;  w_opb = r_sin; end
            S_P2:    begin w_opa = r_alpha; w_opb = r_sin; end
            S_P3:    begin w_opa = r_beta;  w_opb = r_cos; end
            default: begin w_opa = '0;      w_opb = '0;    end
        endcase
    end

    // Operands are sign-extended so the product is computed at full 2*D_WIDTH.
    assign w_ext_a = {{D_WIDTH{w_opa[D_WIDTH-1]}}, w_opa};
    assign w_ext_b = {{D_WIDTH{w_opb[D_WIDTH-1]}}, w_opb};
    assign w_prod  = w_ext_a * w_ext_b;
    assign w_shift = w_prod >>> Q_BITS;
    assign w_term  = {w_shift[PW-1], w_shift};

    function automatic logic signed [D_WIDTH-1:0] sat(input logic signed [AW-1:0] a);
        if (a > ACC_MAX)      return ACC_MAX[D_WIDTH-1:0];
        else if (a < ACC_MIN) return ACC_MIN[D_WIDTH-1:0];
        else                  return a[D_WIDTH-1:0];
    endfunction

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= S_IDLE;
            r_alpha <= '0;
            r_beta  <= '0;
            r_sin   <= '0;
            r_cos   <= '0;
            r_acc_d <= '0;
            r_acc_q <= '0;
            d       <= '0;
            q       <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_alpha <= alpha;
                        r_beta  <= beta;
                        r_sin   <= sin;
                        r_cos   <= cos;
                        r_acc_d <= '0;
                        r_acc_q <= '0;
                        busy    <= 1'b1;
                        r_state <= S_P0;
                    end
                end
                S_P0: begin
                    r_acc_d <= w_term;
                    r_state <= S_P1;
                end
                S_P1: begin
                    r_acc_d <= r_acc_d + w_term;
                    r_state <= S_P2;
                end
                S_P2: begin
                    r_acc_q <= -w_term;
                    r_state <= S_P3;
                end
                S_P3: begin
                    r_acc_q <= r_acc_q + w_term;
                    r_state <= S_OUT;
                end
                S_OUT: begin
                    d       <= sat(r_acc_d);
                    q       <= sat(r_acc_q);
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_park_transform.sv
// Directed bench for park_transform: expected d/q queued at start, checked on each done.
module tb_park_transform;
    localparam int Q = 10;

    typedef struct {
        string              tag;
        logic signed [31:0] d;
        logic signed [31:0] q;
    } exp_t;

    logic clk = 1'b0;
    logic rstb;
    logic signed [31:0] alpha, beta, sn, cs, d, q;
    logic start, done, busy;
    logic signed [15:0] a16, b16, s16, c16, d16, q16;
    logic start16, done16, busy16;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_done  = 0;
    logic prev_done = 1'b0;

    always #5 clk = ~clk;

    park_transform u_dut (
        .clk(clk), .rstb(rstb), .alpha(alpha), .beta(beta), .sin(sn), .cos(cs),
        .start(start), .d(d), .q(q), .done(done), .busy(busy)
    );

    park_transform #(.D_WIDTH(16), .Q_BITS(10)) u_dut16 (
        .clk(clk), .rstb(rstb), .alpha(a16), .beta(b16), .sin(s16), .cos(c16),
        .start(start16), .d(d16), .q(q16), .done(done16), .busy(busy16)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic signed [31:0] a, b, s, c, input int w,
                                  output logic signed [31:0] ed, output logic signed [31:0] eq);
        logic signed [65:0] xa, xb, xs, xc, sd, sq, mx, mn;
        xa = a; xb = b; xs = s; xc = c;
        sd = ((xa * xc) >>> Q) + ((xb * xs) >>> Q);
        sq = ((xb * xc) >>> Q) - ((xa * xs) >>> Q);
        mx = (66'sd1 <<< (w - 1)) - 66'sd1;
        mn = -mx - 66'sd1;
        if (sd > mx) sd = mx; else if (sd < mn) sd = mn;
        if (sq > mx) sq = mx; else if (sq < mn) sq = mn;
        ed = sd[31:0];
        eq = sq[31:0];
    endfunction

    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            n_done++;
            chk("done_not_consecutive", prev_done, 0);
            if (sb.size() == 0) begin
                chk("unexpected_done", done, 0);
            end else begin
                e = sb.pop_front();
                chk({e.tag, "_d"}, d, e.d);
                chk({e.tag, "_q"}, q, e.q);
            end
        end
        prev_done = done;
    end

    task automatic push_exp(input string tag, input logic signed [31:0] a, b, s, c);
        exp_t e;
        e.tag = tag;
        model(a, b, s, c, 32, e.d, e.q);
        sb.push_back(e);
    endtask

    task automatic run_op(input string tag, input logic signed [31:0] a, b, s, c);
        int k;
        alpha = a; beta = b; sn = s; cs = c;
        push_exp(tag, a, b, s, c);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        k = 1;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_latency"}, k, 6);
        chk({tag, "_busy_at_done"}, busy, 0);
        @(negedge clk);
        chk({tag, "_done_width"}, done, 0);
    endtask

    task automatic run16(input string tag, input logic signed [15:0] a, b, s, c);
        int k;
        logic signed [31:0] ed, eq;
        a16 = a; b16 = b; s16 = s; c16 = c;
        model(a, b, s, c, 16, ed, eq);
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        chk({tag, "_busy"}, busy16, 1);
        k = 1;
        while (!done16 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_latency"}, k, 6);
        chk({tag, "_d"}, d16, ed);
        chk({tag, "_q"}, q16, eq);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int k, n0;
        logic signed [31:0] rs, rc;
        rstb = 1'b0; start = 1'b0; start16 = 1'b0;
        alpha = '0; beta = '0; sn = '0; cs = '0;
        a16 = '0; b16 = '0; s16 = '0; c16 = '0;
        repeat (2) @(negedge clk);
        chk("reset_d", d, 0);
        chk("reset_q", q, 0);
        chk("reset_done", done, 0);
        chk("reset_busy", busy, 0);
        rstb = 1'b1;
        @(negedge clk);

        run_op("identity", 1024, 0, 0, 1024);
        run_op("theta90", 1024, 0, 1024, 0);
        run_op("theta45", 1024, 0, 724, 724);
        run_op("floor_neg", -1, 0, 0, 1);
        run_op("floor_pos", 1, 0, 0, 1);
        run_op("mixed", -5000, 3000, -724, -700);
        run_op("sat32", 32'sh7fffffff, 32'sh7fffffff, 1024, 1024);
        for (int i = 0; i < 4; i++) begin
            rs = int'($urandom_range(2048, 0)) - 1024;
            rc = int'($urandom_range(2048, 0)) - 1024;
            run_op("random", $urandom, $urandom, rs, rc);
        end

        run16("sat16_pos", 16'sd32767, 16'sd32767, 16'sd1024, 16'sd1024);
        run16("sat16_neg", -16'sd32768, -16'sd32768, 16'sd1024, 16'sd1024);

        // start and input changes while busy must not disturb the accepted operation
        n0 = n_done;
        alpha = 1000; beta = -2000; sn = 300; cs = 900;
        push_exp("busy_ignore", 1000, -2000, 300, 900);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; alpha = 7; beta = 9; sn = -50; cs = 11;
        @(negedge clk);
        start = 1'b0; alpha = -123; beta = 456; sn = 1000; cs = -1000;
        k = 0;
        while (n_done == n0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        chk("busy_ignore_done_count", n_done, n0 + 1);
        chk("busy_ignore_queue", sb.size(), 0);

        alpha = 3000; beta = -1500; sn = 512; cs = 887;
        for (int i = 0; i < 4; i++) push_exp("held", 3000, -1500, 512, 887);
        start = 1'b1;
        for (int s = 1; s <= 20; s++) begin
            @(negedge clk);
            chk("held_done_timing", done, (s == 6 || s == 12 || s == 18));
        end
        start = 1'b0;
        k = 0;
        while (sb.size() != 0 && k < 12) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        chk("held_queue_drained", sb.size(), 0);

        alpha = 2222; beta = 3333; sn = 100; cs = 1000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rstb = 1'b0;
        #1;
        chk("midreset_d", d, 0);
        chk("midreset_q", q, 0);
        chk("midreset_done", done, 0);
        chk("midreset_busy", busy, 0);
        @(negedge clk);
        rstb = 1'b1;
        repeat (2) @(negedge clk);
        run_op("after_reset", 2222, 3333, 100, 1000);

        repeat (3) @(negedge clk);
        chk("final_queue_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
